// File: rtl/dmem_stage.sv
// Data-memory access stage: byte/half/word loads and stores on an internal RAM,
// with misaligned accesses split into two aligned beats behind a one-cycle stall.
module dmem_stage #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr_in,
  input  logic [31:0] store_data_in,
  input  logic [2:0]  type_dm_in,
  input  logic        load_in,
  input  logic        store_in,
  output logic [31:0] load_data_out,
  output logic        load_valid_out,
  output logic        stall_out
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic {IDLE, SECOND} state_t;

  state_t            r_state, w_state_nxt;
  logic [31:0]       r_mem [DEPTH];
  logic [23:0]       r_hold, w_hold_nxt;
  logic [ADDR_W-1:0] w_idx, w_widx;
  logic [1:0]        w_off, w_n1;
  logic [4:0]        w_sh1, w_sh2;
  logic [2:0]        w_size;
  logic [3:0]        w_full, w_be, w_we;
  logic              w_legal, w_sgn, w_load, w_store, w_mis;
  logic [31:0]       w_rdata, w_wdata, w_raw, w_ext;
  logic              w_unused;

  assign w_unused = ^addr_in[31:ADDR_W+2];

  // Access-type decode (funct3)
  always_comb begin
    w_legal = 1'b1;
    w_sgn   = 1'b0;
    w_size  = 3'd1;
    w_full  = 4'b0001;
    case (type_dm_in)
      3'b000: w_sgn = 1'b1;
      3'b001: begin w_sgn = 1'b1; w_size = 3'd2; w_full = 4'b0011; end
      3'b010: begin w_size = 3'd4; w_full = 4'b1111; end
      3'b100: w_sgn = 1'b0;
      3'b101: begin w_size = 3'd2; w_full = 4'b0011; end
      default: w_legal = 1'b0;
    endcase
  end

  assign w_idx   = addr_in[ADDR_W+1:2];
  assign w_off   = addr_in[1:0];
  assign w_n1    = 2'(3'd4 - {1'b0, w_off});
  assign w_sh1   = {w_off, 3'b000};
  assign w_sh2   = {w_n1, 3'b000};
  assign w_store = store_in & w_legal;
  assign w_load  = load_in & ~store_in & w_legal;
  assign w_mis   = (w_load | w_store) &
                   (((w_size == 3'd2) && (w_off == 2'd3)) ||
                    ((w_size == 3'd4) && (w_off != 2'd0)));

  // Beat 1 lives in word idx starting at offset; beat 2 fills the low lanes of idx+1
  assign w_widx  = (r_state == SECOND) ? ADDR_W'(w_idx + ADDR_W'(1)) : w_idx;
  assign w_rdata = r_mem[w_widx];
  assign w_be    = (r_state == SECOND) ? (w_full >> w_n1) : 4'(8'({4'b0000, w_full}) << w_off);
  assign w_wdata = (r_state == SECOND) ? (store_data_in >> w_sh2) : (store_data_in << w_sh1);
  assign w_raw   = (r_state == SECOND) ? ({8'h00, r_hold} | (w_rdata << w_sh2))
                                       : (w_rdata >> w_sh1);

  always_comb begin
    case (w_size)
      3'd1:    w_ext = {{24{w_sgn & w_raw[7]}}, w_raw[7:0]};
      3'd2:    w_ext = {{16{w_sgn & w_raw[15]}}, w_raw[15:0]};
      default: w_ext = w_raw;
    endcase
  end

  // Next state, hold capture, write enables and outputs
  always_comb begin
    w_state_nxt    = r_state;
    w_hold_nxt     = r_hold;
    w_we           = 4'b0000;
    stall_out      = 1'b0;
    load_valid_out = 1'b0;
    load_data_out  = 32'h0;
    if (rst) begin
      w_state_nxt = IDLE;
      w_hold_nxt  = 24'h0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_store) w_we = w_be;
          if (w_mis) begin
            stall_out   = 1'b1;
            w_state_nxt = SECOND;
            if (w_load) w_hold_nxt = w_raw[23:0];
          end else if (w_load) begin
            load_valid_out = 1'b1;
            load_data_out  = w_ext;
          end
        end
        SECOND: begin
          if (w_store) w_we = w_be;
          if (w_load) begin
            load_valid_out = 1'b1;
            load_data_out  = w_ext;
          end
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    r_state <= w_state_nxt;
    r_hold  <= w_hold_nxt;
  end

  // RAM is not reset; per-byte write
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (w_we[b]) r_mem[w_widx][8*b +: 8] <= w_wdata[8*b +: 8];
    end
  end

endmodule

// File: tb/tb_dmem_stage.sv
// Randomised bench for dmem_stage against a byte-array memory model.
module tb_dmem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr_in;
  logic [31:0] store_data_in;
  logic [2:0]  type_dm_in;
  logic        load_in;
  logic        store_in;
  logic [31:0] load_data_out;
  logic        load_valid_out;
  logic        stall_out;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] mdl [4096];

  dmem_stage #(.ADDR_W(10)) dut (
    .clk(clk), .rst(rst), .addr_in(addr_in), .store_data_in(store_data_in),
    .type_dm_in(type_dm_in), .load_in(load_in), .store_in(store_in),
    .load_data_out(load_data_out), .load_valid_out(load_valid_out), .stall_out(stall_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int ty_size(input logic [2:0] ty);
    if (ty[1:0] == 2'd0) return 1;
    if (ty[1:0] == 2'd1) return 2;
    return 4;
  endfunction

  function automatic bit ty_legal(input logic [2:0] ty);
    return (ty == 3'd0) || (ty == 3'd1) || (ty == 3'd2) || (ty == 3'd4) || (ty == 3'd5);
  endfunction

  function automatic logic [31:0] mdl_load(input logic [2:0] ty, input logic [31:0] a);
    int sz;
    logic [31:0] v;
    logic [11:0] ba;
    sz = ty_size(ty);
    v = 32'h0;
    for (int i = 0; i < sz; i++) begin
      ba = 12'(a[11:0] + 12'(i));
      v = v | (32'(mdl[ba]) << (8 * i));
    end
    if (!ty[2] && sz < 4 && v[8*sz-1]) v = v | ~((32'd1 << (8 * sz)) - 32'd1);
    return v;
  endfunction

  // One full access; called and returns one cycle after a rising edge
  task automatic do_op(input bit ld, input bit st, input logic [2:0] ty,
                       input logic [31:0] a, input logic [31:0] d, output logic [31:0] got);
    int sz;
    bit legal, mis, vld;
    logic [31:0] expv;
    logic [11:0] ba;
    sz    = ty_size(ty);
    legal = ty_legal(ty);
    mis   = legal && (ld || st) && ((sz == 2 && a[1:0] == 2'd3) || (sz == 4 && a[1:0] != 2'd0));
    vld   = legal && ld && !st;
    expv  = vld ? mdl_load(ty, a) : 32'h0;
    addr_in = a; store_data_in = d; type_dm_in = ty; load_in = ld; store_in = st;
    @(negedge clk);
    if (mis) begin
      chk("stall_b1", 32'(stall_out), 32'd1);
      chk("valid_b1", 32'(load_valid_out), 32'd0);
      chk("data_b1", load_data_out, 32'h0);
      @(posedge clk); #1;
      @(negedge clk);
    end
    chk("stall", 32'(stall_out), 32'd0);
    chk("valid", 32'(load_valid_out), 32'(vld));
    chk("data", load_data_out, expv);
    got = load_data_out;
    @(posedge clk); #1;
    load_in = 1'b0; store_in = 1'b0;
    if (legal && st) begin
      for (int i = 0; i < sz; i++) begin
        ba = 12'(a[11:0] + 12'(i));
        mdl[ba] = d[8*i +: 8];
      end
    end
  endtask

  initial begin
    logic [31:0] got;
    rst = 1'b1; addr_in = 32'h10; store_data_in = 32'h0; type_dm_in = 3'b010;
    load_in = 1'b1; store_in = 1'b0;
    @(negedge clk);
    chk("rst_stall", 32'(stall_out), 32'd0);
    chk("rst_valid", 32'(load_valid_out), 32'd0);
    chk("rst_data", load_data_out, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; load_in = 1'b0;

    for (int w = 0; w < 1024; w++) do_op(1'b0, 1'b1, 3'b010, 32'(w * 4), $urandom, got);

    do_op(0, 1, 3'b010, 32'h10, 32'hDEADBEEF, got);
    do_op(1, 0, 3'b010, 32'h10, 0, got); chk("lw_10", got, 32'hDEADBEEF);
    do_op(1, 0, 3'b000, 32'h13, 0, got); chk("lb_13", got, 32'hFFFFFFDE);
    do_op(1, 0, 3'b100, 32'h13, 0, got); chk("lbu_13", got, 32'h000000DE);
    do_op(0, 1, 3'b010, 32'h20, 32'h0, got);
    do_op(0, 1, 3'b001, 32'h22, 32'h00001234, got);
    do_op(1, 0, 3'b010, 32'h20, 0, got); chk("lw_20", got, 32'h12340000);
    do_op(1, 0, 3'b001, 32'h22, 0, got); chk("lh_22", got, 32'h00001234);
    do_op(0, 1, 3'b010, 32'h14, 32'h44332211, got);
    do_op(1, 0, 3'b010, 32'h11, 0, got); chk("lw_11", got, 32'h11DEADBE);
    do_op(1, 0, 3'b101, 32'h13, 0, got); chk("lhu_13", got, 32'h000011DE);
    do_op(0, 1, 3'b010, 32'h1E, 32'hAABBCCDD, got);
    do_op(1, 0, 3'b010, 32'h1C, 0, got); chk("sw1e_hi", got[31:16], 32'h0000CCDD);
    do_op(1, 0, 3'b010, 32'h20, 0, got); chk("sw1e_lo", got[15:0], 32'h0000AABB);
    do_op(0, 1, 3'b000, 32'hFFF, 32'h80, got);
    do_op(0, 1, 3'b000, 32'h000, 32'h7F, got);
    do_op(1, 0, 3'b001, 32'hFFF, 0, got); chk("wrap_lh", got, 32'h00007F80);

    // rst in the second cycle of a misaligned store
    addr_in = 32'h1E; store_data_in = 32'h11223344; type_dm_in = 3'b010;
    load_in = 1'b0; store_in = 1'b1;
    @(negedge clk); chk("rs_stall1", 32'(stall_out), 32'd1);
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    chk("rs_stall2", 32'(stall_out), 32'd0);
    chk("rs_valid2", 32'(load_valid_out), 32'd0);
    @(posedge clk); #1; rst = 1'b0; store_in = 1'b0;
    mdl[12'h01E] = 8'h44; mdl[12'h01F] = 8'h33;
    do_op(1, 0, 3'b010, 32'h1C, 0, got); chk("rs_w1c", got[31:16], 32'h00003344);
    do_op(1, 0, 3'b010, 32'h20, 0, got);

    // rst in the first cycle of a misaligned store: nothing written, no stall
    addr_in = 32'h41; store_data_in = 32'h55667788; type_dm_in = 3'b010;
    store_in = 1'b1; rst = 1'b1;
    @(negedge clk); chk("ri_stall", 32'(stall_out), 32'd0);
    @(posedge clk); #1; rst = 1'b0; store_in = 1'b0;
    do_op(1, 0, 3'b010, 32'h40, 0, got);
    do_op(1, 0, 3'b010, 32'h44, 0, got);

    for (int k = 0; k < 600; k++) begin
      logic [31:0] a;
      a = $urandom;
      if (k % 3 == 0) a = {$urandom_range(0, 1) == 1 ? 20'hFFFFF : 20'h0, 12'(a[11:0])};
      do_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            3'($urandom_range(0, 7)), a, $urandom, got);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
